sonic_echo_responder: RTL and testbench

//  Cycle-accurate model of the HC-SR04 ultrasonic sensor, i.e. the responder end of the trig/echo

---
 rtl/sonic_echo_responder.sv | 209 ++++++++++++++++++++
 tb/tb_sonic_echo_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_echo_responder.sv
// sonic_echo_responder
//   Cycle-accurate responder end of the HC-SR04 trig/echo protocol. A Trig pulse
//   that is long enough starts a measurement. The block waits out the acoustic
//   burst, then holds Echo high for a width proportional to the programmed
//   distance, or for the no-echo timeout. A dead time follows, during which
//   further Trig activity is ignored.
//
//   Ports
//     clk         in   1  system clock
//     rst_n       in   1  synchronous reset, active low
//     trig        in   1  Trig from the initiator, asynchronous
//     dist_cm     in   9  simulated distance in cm
//     obstacle    in   1  1: obstacle present at dist_cm, 0: nothing in range
//     echo        out  1  Echo to the initiator
//     busy        out  1  high in every state except IDLE
//     short_trig  out  1  one-cycle pulse when a Trig is rejected as too short
//     meas_cnt    out  8  completed measurements, wraps 255 -> 0
//
//   Optional build macro SONIC_NOISE_EN: a 16-bit Galois LFSR (seed 16'hACE1)
//   adds lfsr[7:0] extra cycles to in-range echo widths and advances once per
//   completed measurement. Without the macro the echo width is exact.
`timescale 1ns/1ps

module sonic_echo_responder #(
   parameter int TRIG_MIN_CYC = 1000,
   parameter int BURST_CYC    = 20000,
   parameter int UNIT_CYC     = 5800,
   parameter int MAX_CM       = 400,
   parameter int NOECHO_CYC   = 3800000,
   parameter int HOLDOFF_CYC  = 6000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trig,
   input  logic [8:0] dist_cm,
   input  logic       obstacle,
   output logic       echo,
   output logic       busy,
   output logic       short_trig,
   output logic [7:0] meas_cnt
);

   // The inner counter doubles as the flat timeout counter, so it must hold
   // whichever of UNIT_CYC / NOECHO_CYC is larger.
   localparam int UNIT_MAX = (NOECHO_CYC > UNIT_CYC) ? NOECHO_CYC : UNIT_CYC;
   localparam int UW = $clog2(UNIT_MAX + 1);
   localparam int CW = $clog2(MAX_CM + 1);
   localparam int BW = $clog2(BURST_CYC + 1);
   localparam int HW = $clog2(HOLDOFF_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_BURST,
      S_ECHO,
      S_HOLDOFF
   } state_t;

   state_t        state;
   logic          trig_meta;
   logic          trig_s;
   logic          trig_prev;
   logic [15:0]   hi_cnt;
   logic [BW-1:0] burst_cnt;
   logic [UW-1:0] unit_cnt;
   logic [CW-1:0] cm_cnt;
   logic [HW-1:0] hold_cnt;
   logic [8:0]    snap_dist;
   logic          snap_obs;

   // Synchroniser and edge-history flops are left out of reset on purpose:
   // a Trig held high through reset must not look like a fresh rising edge.
   always_ff @(posedge clk) begin
      trig_meta <= trig;
      trig_s    <= trig_meta;
      trig_prev <= trig_s;
   end

   // Echo width is unit_last+1 cycles per step, cm_last+1 steps. The timeout
   // case collapses to a single step of NOECHO_CYC cycles.
   logic          in_range;
   logic [8:0]    eff_dist;
   logic [UW-1:0] unit_last;
   logic [CW-1:0] cm_last;
   logic          nested_last;
   logic          echo_done;

   assign in_range    = snap_obs && (int'(snap_dist) <= MAX_CM);
   assign eff_dist    = (snap_dist == 9'd0) ? 9'd1 : snap_dist;
   assign unit_last   = in_range ? UW'(UNIT_CYC - 1) : UW'(NOECHO_CYC - 1);
   assign cm_last     = in_range ? CW'(eff_dist - 9'd1) : '0;
   assign nested_last = (unit_cnt == unit_last) && (cm_cnt == cm_last);

`ifdef SONIC_NOISE_EN
   logic [15:0] lfsr;
   logic [7:0]  extra;
   logic [7:0]  noise_cnt;
   logic        tail;

   // Jitter applies to real echoes only; the timeout width stays exact.
   assign extra     = in_range ? lfsr[7:0] : 8'd0;
   assign echo_done = tail ? (noise_cnt == extra - 8'd1)
                           : (nested_last && (extra == 8'd0));
`else
   assign echo_done = nested_last;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         echo       <= 1'b0;
         busy       <= 1'b0;
         short_trig <= 1'b0;
         meas_cnt   <= 8'd0;
         hi_cnt     <= 16'd0;
         burst_cnt  <= '0;
         unit_cnt   <= '0;
         cm_cnt     <= '0;
         hold_cnt   <= '0;
         snap_dist  <= 9'd0;
         snap_obs   <= 1'b0;
`ifdef SONIC_NOISE_EN
         lfsr       <= 16'hACE1;
         noise_cnt  <= 8'd0;
         tail       <= 1'b0;
`endif
      end else begin
         short_trig <= 1'b0;
         case (state)
            S_IDLE: begin
               if (trig_s && !trig_prev) begin
                  state  <= S_TRIG;
                  busy   <= 1'b1;
                  hi_cnt <= 16'd1;
               end
            end
            S_TRIG: begin
               if (trig_s) begin
                  if (hi_cnt != 16'hFFFF)
                     hi_cnt <= hi_cnt + 16'd1;
               end else if (hi_cnt >= 16'(TRIG_MIN_CYC)) begin
                  // Freeze the target so later input changes cannot skew
                  // the measurement in flight.
                  state     <= S_BURST;
                  burst_cnt <= '0;
                  snap_dist <= dist_cm;
                  snap_obs  <= obstacle;
               end else begin
                  state      <= S_IDLE;
                  busy       <= 1'b0;
                  short_trig <= 1'b1;
               end
            end
            S_BURST: begin
               if (burst_cnt == BW'(BURST_CYC - 1)) begin
                  state    <= S_ECHO;
                  echo     <= 1'b1;
                  unit_cnt <= '0;
                  cm_cnt   <= '0;
`ifdef SONIC_NOISE_EN
                  tail     <= 1'b0;
`endif
               end else begin
                  burst_cnt <= burst_cnt + BW'(1);
               end
            end
            S_ECHO: begin
               if (echo_done) begin
                  state    <= S_HOLDOFF;
                  echo     <= 1'b0;
                  meas_cnt <= meas_cnt + 8'd1;
                  hold_cnt <= '0;
`ifdef SONIC_NOISE_EN
                  lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
`endif
               end
`ifdef SONIC_NOISE_EN
               else if (tail) begin
                  noise_cnt <= noise_cnt + 8'd1;
               end else if (nested_last) begin
                  tail      <= 1'b1;
                  noise_cnt <= 8'd0;
               end
`endif
               else if (unit_cnt == unit_last) begin
                  unit_cnt <= '0;
                  cm_cnt   <= cm_cnt + CW'(1);
               end else begin
                  unit_cnt <= unit_cnt + UW'(1);
               end
            end
            S_HOLDOFF: begin
               if (hold_cnt == HW'(HOLDOFF_CYC - 1)) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               echo  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Testbench for sonic_echo_responder with shortened timing parameters.
// The driver issues Trig pulses and pushes the expected response of each
// accepted or rejected request into a queue; an independent monitor on the
// falling clock edge pops and compares whenever the DUT shows an echo pulse
// or a short_trig pulse.
`timescale 1ns/1ps

module tb_sonic_echo_responder;

   localparam int K_NONE  = 0;
   localparam int K_ECHO  = 1;
   localparam int K_SHORT = 2;
   localparam int K_ABORT = 3;

   // Trig low seen by the bench -> Echo high seen by the bench:
   // 1 edge to sample the low, 2 synchroniser edges, 20 burst cycles.
   localparam int RISE_DLY  = 23;
   // Trig low -> short_trig seen: 1 + 2 synchroniser edges.
   localparam int SHORT_DLY = 3;

   typedef struct {
      int kind;
      int width;
      int meas;
      int fall_n;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       trig;
   logic [8:0] dist_cm;
   logic       obstacle;
   logic       echo;
   logic       busy;
   logic       short_trig;
   logic [7:0] meas_cnt;

   exp_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   ncyc    = 0;
   int   pending = 0;
   int   exp_meas = 0;

   sonic_echo_responder #(
      .TRIG_MIN_CYC(10),
      .BURST_CYC   (20),
      .UNIT_CYC    (5),
      .MAX_CM      (400),
      .NOECHO_CYC  (300),
      .HOLDOFF_CYC (50)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig      (trig),
      .dist_cm   (dist_cm),
      .obstacle  (obstacle),
      .echo      (echo),
      .busy      (busy),
      .short_trig(short_trig),
      .meas_cnt  (meas_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   exp_t cur;
   bit   cur_valid  = 1'b0;
   int   rise_n     = 0;
   bit   echo_prev  = 1'b0;
   bit   short_prev = 1'b0;
   int   short_run  = 0;
   bit   rst_prev   = 1'b0;

   always @(negedge clk) begin
      exp_t it;
      ncyc++;
      // echo rising
      if (echo === 1'b1 && !echo_prev) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_echo: echo rose with no request outstanding (t=%0t)", $time);
         end else begin
            cur       = sb.pop_front();
            cur_valid = 1'b1;
            rise_n    = ncyc;
            chk("echo_for_short_req", int'(cur.kind == K_SHORT), 0);
            chk("echo_rise_delay", ncyc - cur.fall_n, RISE_DLY);
            chk("busy_at_echo", int'(busy), 1);
         end
      end
      // echo falling
      if (echo !== 1'b1 && echo_prev && cur_valid) begin
         if (cur.kind == K_ABORT) begin
            chk("abort_one_edge_after_reset", int'(rst_prev), 0);
            chk("abort_busy", int'(busy), 0);
         end else begin
            chk("echo_width", ncyc - rise_n, cur.width);
         end
         chk("meas_cnt", int'(meas_cnt), cur.meas);
         cur_valid = 1'b0;
         pending--;
      end
      // short_trig
      if (short_trig === 1'b1) begin
         if (!short_prev) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_short: short_trig with no short request (t=%0t)", $time);
            end else begin
               it = sb.pop_front();
               chk("short_kind", it.kind, K_SHORT);
               chk("short_delay", ncyc - it.fall_n, SHORT_DLY);
               chk("short_echo", int'(echo), 0);
               chk("short_busy", int'(busy), 0);
               chk("short_meas", int'(meas_cnt), it.meas);
               pending--;
            end
         end
         short_run++;
      end else if (short_prev) begin
         chk("short_len", short_run, 1);
         short_run = 0;
      end
      echo_prev  = (echo === 1'b1);
      short_prev = (short_trig === 1'b1);
      rst_prev   = rst_n;
   end

   // ---------------- driver ----------------
   task automatic pulse(input int n, input int kind, input int width);
      exp_t e;
      @(posedge clk); #2 trig = 1'b1;
      repeat (n) @(posedge clk);
      #2 trig = 1'b0;
      if (kind != K_NONE) begin
         if (kind == K_ECHO)  exp_meas = (exp_meas + 1) % 256;
         if (kind == K_ABORT) exp_meas = 0;
         e.kind   = kind;
         e.width  = width;
         e.meas   = exp_meas;
         e.fall_n = ncyc + 1;
         sb.push_back(e);
         pending++;
         $display("req kind=%0d trig_len=%0d dist=%0d obs=%0d exp_width=%0d exp_meas=%0d",
                  kind, n, dist_cm, obstacle, width, exp_meas);
      end
   endtask

   task automatic wait_done(input int bound, input string tag);
      int i = 0;
      while ((pending != 0 || busy !== 1'b0) && i < bound) begin
         @(negedge clk); #1;
         i++;
      end
      if (i >= bound) begin
         checks++; errors++;
         $display("FAIL timeout_%s: still pending=%0d busy=%0b after %0d cycles", tag, pending, busy, bound);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_echo(input logic lvl, input int bound, input string tag);
      int i = 0;
      while (echo !== lvl && i < bound) begin
         @(negedge clk); #1;
         i++;
      end
      if (i >= bound) begin
         checks++; errors++;
         $display("FAIL timeout_%s: echo=%0b, wanted %0b", tag, echo, lvl);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      trig = 1'b0; rst_n = 1'b0; dist_cm = 9'd0; obstacle = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_echo", int'(echo), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_short", int'(short_trig), 0);
      chk("rst_meas", int'(meas_cnt), 0);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // nominal: 7 cm -> 35 cycles
      #2 dist_cm = 9'd7; obstacle = 1'b1;
      pulse(12, K_ECHO, 35);  wait_done(3000, "t1");
      // too short
      pulse(5, K_SHORT, 0);   wait_done(3000, "t2");
      // exactly the minimum Trig length, 1 cm
      #2 dist_cm = 9'd1;
      pulse(10, K_ECHO, 5);   wait_done(3000, "t3");
      // one cycle below the minimum
      pulse(9, K_SHORT, 0);   wait_done(3000, "t4");
      // no obstacle -> timeout
      #2 dist_cm = 9'd7; obstacle = 1'b0;
      pulse(12, K_ECHO, 300); wait_done(3000, "t5");
      // beyond range -> timeout
      #2 dist_cm = 9'd450; obstacle = 1'b1;
      pulse(12, K_ECHO, 300); wait_done(3000, "t6");
      // largest in-range distance
      #2 dist_cm = 9'd400;
      pulse(12, K_ECHO, 2000); wait_done(3000, "t7");
      // one past the maximum
      #2 dist_cm = 9'd401;
      pulse(12, K_ECHO, 300); wait_done(3000, "t8");
      // zero distance behaves as 1 cm
      #2 dist_cm = 9'd0;
      pulse(12, K_ECHO, 5);   wait_done(3000, "t9");

      // distance change during BURST and extra Trig activity must not disturb
      #2 dist_cm = 9'd7;
      pulse(12, K_ECHO, 35);
      repeat (5) @(posedge clk);
      #2 dist_cm = 9'd30;
      wait_echo(1'b1, 200, "t10_rise");
      pulse(3, K_NONE, 0);
      pulse(14, K_NONE, 0);
      wait_echo(1'b0, 200, "t10_fall");
      pulse(12, K_NONE, 0);
      pulse(4, K_NONE, 0);
      wait_done(3000, "t10");

      // reset in the middle of ECHO
      #2 dist_cm = 9'd7;
      pulse(12, K_ABORT, 0);
      wait_echo(1'b1, 200, "t11_rise");
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      wait_done(3000, "t11");
      pulse(12, K_ECHO, 35);  wait_done(3000, "t11b");

      // back-to-back measurements until meas_cnt wraps to 0
      #2 dist_cm = 9'd1;
      for (int i = 0; i < 255; i++) begin
         pulse(10, K_ECHO, 5);
         wait_done(400, "wrap");
      end

      repeat (5) @(posedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      chk("pending_zero", pending, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
